// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan controller.
//   scan_state_e : scan FSM states
//   SEG_OFF      : all segments dark (active-low)
//   SEG_HEX      : active-low {dp,g..a} codes for hex digits 0..F, dp always off
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    GUARD = 2'd2
  } scan_state_e;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  // Entry [n] holds the code for hex digit n (listed F down to 0).
  localparam logic [15:0][7:0] SEG_HEX = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hD8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment code.
//   nibble   in  4  hex value 0..F
//   seg_code out 8  active-low {dp,g..a}, dp always 1
module seg7_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] seg_code
);

  always_comb begin
    seg_code = SEG_HEX[nibble];
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
// One shared decoder is swept across NUM_DIGITS digits with an all-off guard
// gap between slots. Display data is double-buffered and only swapped at a
// frame boundary so a frame never mixes old and new digits.
//   CLK        in   system clock
//   Reset      in   asynchronous active-high reset
//   enable     in   1 = scan, 0 = dark
//   load       in   strobe: capture data_in/blank_in into the pending buffer
//   data_in    in   4*NUM_DIGITS hex nibbles, nibble k -> digit k (0 = rightmost)
//   blank_in   in   NUM_DIGITS, 1 = digit k stays dark
//   anode      out  active-low digit enables (registered)
//   seg        out  active-low {dp,g..a} (registered)
//   frame_done out  pulse in the cycle the digit index wraps to 0
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  output logic [NUM_DIGITS-1:0]     anode,
  output logic [7:0]                seg,
  output logic                      frame_done
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
  localparam int unsigned GRD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  scan_state_e                    state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [DIV_W-1:0]               div_cnt_q, div_cnt_d;
  logic [GRD_W-1:0]               grd_cnt_q, grd_cnt_d;
  logic                           first_q, first_d;
  logic [NUM_DIGITS-1:0][3:0]     active_data_q, active_data_d;
  logic [NUM_DIGITS-1:0]          active_blank_q, active_blank_d;
  logic [NUM_DIGITS-1:0][3:0]     pend_data_q, pend_data_d;
  logic [NUM_DIGITS-1:0]          pend_blank_q, pend_blank_d;
  logic                           pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0]          anode_q, anode_d;
  logic [7:0]                     seg_q, seg_d;
  logic                           wrap;
  logic [7:0]                     dec_code;

  seg7_hex_decode u_dec (
    .nibble   (active_data_q[idx_q]),
    .seg_code (dec_code)
  );

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    div_cnt_d      = div_cnt_q;
    grd_cnt_d      = grd_cnt_q;
    first_d        = first_q;
    active_data_d  = active_data_q;
    active_blank_d = active_blank_q;
    pend_data_d    = pend_data_q;
    pend_blank_d   = pend_blank_q;
    pend_valid_d   = pend_valid_q;
    wrap           = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = GUARD;
          idx_d     = '0;
          div_cnt_d = '0;
          grd_cnt_d = '0;
          first_d   = 1'b1;
        end
      end
      SCAN: begin
        if (div_cnt_q == DIV_W'(REFRESH_DIV - 1)) begin
          state_d   = GUARD;
          div_cnt_d = '0;
          grd_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      GUARD: begin
        if (grd_cnt_q == GRD_W'(GUARD_CYCLES - 1)) begin
          state_d   = SCAN;
          grd_cnt_d = '0;
          first_d   = 1'b0;
          // The guard entered from IDLE holds idx at 0, so leaving it is a
          // frame start just like a normal wrap from the last digit.
          if (first_q || idx_q == IDX_W'(NUM_DIGITS - 1)) begin
            idx_d = '0;
            wrap  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          grd_cnt_d = grd_cnt_q + GRD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d   = IDLE;
      idx_d     = '0;
      div_cnt_d = '0;
      grd_cnt_d = '0;
      first_d   = 1'b0;
      wrap      = 1'b0;
    end

    // A load coinciding with the commit goes straight to the active buffer.
    if (wrap && load) begin
      active_data_d  = data_in;
      active_blank_d = blank_in;
      pend_valid_d   = 1'b0;
    end else if (wrap && pend_valid_q) begin
      active_data_d  = pend_data_q;
      active_blank_d = pend_blank_q;
      pend_valid_d   = 1'b0;
    end else if (load) begin
      pend_data_d    = data_in;
      pend_blank_d   = blank_in;
      pend_valid_d   = 1'b1;
    end

    anode_d = '1;
    seg_d   = SEG_OFF;
    if (enable && state_q == SCAN && !active_blank_q[idx_q]) begin
      anode_d[idx_q] = 1'b0;
      seg_d          = dec_code;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      div_cnt_q      <= '0;
      grd_cnt_q      <= '0;
      first_q        <= 1'b0;
      active_data_q  <= '0;
      active_blank_q <= '0;
      pend_data_q    <= '0;
      pend_blank_q   <= '0;
      pend_valid_q   <= 1'b0;
      anode_q        <= '1;
      seg_q          <= SEG_OFF;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      div_cnt_q      <= div_cnt_d;
      grd_cnt_q      <= grd_cnt_d;
      first_q        <= first_d;
      active_data_q  <= active_data_d;
      active_blank_q <= active_blank_d;
      pend_data_q    <= pend_data_d;
      pend_blank_q   <= pend_blank_d;
      pend_valid_q   <= pend_valid_d;
      anode_q        <= anode_d;
      seg_q          <= seg_d;
    end
  end

  assign anode      = anode_q;
  assign seg        = seg_q;
  assign frame_done = wrap;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
module tb_seg_scan_ctrl;

  logic        CLK;
  logic        Reset;
  logic        enable;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  blank_in;
  logic [3:0]  anode;
  logic [7:0]  seg;
  logic        frame_done;

  int   checks = 0;
  int   errors = 0;
  logic [3:0] prev_anode = 4'hF;

  seg_scan_ctrl #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .GUARD_CYCLES (1)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .enable     (enable),
    .load       (load),
    .data_in    (data_in),
    .blank_in   (blank_in),
    .anode      (anode),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL global_timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1 time unit after the edge, with per-cycle safety checks.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (!Reset) begin
      chk("onehot0", 32'($onehot0(~anode)), 32'd1);
      chk("guard_gap", 32'((prev_anode == 4'hF) || (anode == 4'hF) || (anode == prev_anode)), 32'd1);
    end
    prev_anode = anode;
  endtask

  task automatic wait_fd(input int max_cycles);
    int found;
    found = 0;
    for (int i = 0; i < max_cycles && found == 0; i++) begin
      tick();
      if (frame_done === 1'b1) found = 1;
    end
    chk("wait_frame_done", 32'(found), 32'd1);
  endtask

  // Called in a frame_done cycle; checks the next 20 cycles (one frame) and
  // ends in the following frame_done cycle. Optional loads at cycles la/lb.
  task automatic check_frame(input logic [3:0][7:0] codes, input logic [3:0] blank,
                             input int la, input logic [15:0] da, input logic [3:0] ba,
                             input int lb, input logic [15:0] db);
    int slot;
    int pos;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    for (int c = 1; c <= 20; c++) begin
      tick();
      load     = 1'b0;
      blank_in = 4'h0;
      slot     = (c - 1) / 5;
      pos      = (c - 1) % 5;
      exp_an   = 4'hF;
      exp_seg  = 8'hFF;
      if (pos != 0 && !blank[slot]) begin
        exp_an[slot] = 1'b0;
        exp_seg      = codes[slot];
      end
      chk("anode", 32'(anode), 32'(exp_an));
      chk("seg", 32'(seg), 32'(exp_seg));
      chk("frame_done", 32'(frame_done), 32'(c == 20));
      if (c == la) begin
        load = 1'b1; data_in = da; blank_in = ba;
      end
      if (c == lb) begin
        load = 1'b1; data_in = db; blank_in = 4'h0;
      end
    end
  endtask

  initial begin
    Reset    = 1'b1;
    enable   = 1'b0;
    load     = 1'b0;
    data_in  = 16'h0;
    blank_in = 4'h0;

    #1;
    chk("reset_anode", 32'(anode), 32'hF);
    chk("reset_seg", 32'(seg), 32'hFF);
    chk("reset_fd", 32'(frame_done), 32'd0);
    tick();
    tick();
    Reset = 1'b0;
    tick();
    tick();
    chk("idle_anode", 32'(anode), 32'hF);
    chk("idle_seg", 32'(seg), 32'hFF);

    // Enable with no load: all zeros. Load 1A3F mid-frame; not yet visible.
    enable = 1'b1;
    wait_fd(5);
    check_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'h0, 8, 16'h1A3F, 4'h0, 0, 16'h0);
    // 1A3F now shown; two loads this frame, only the second must appear.
    check_frame({8'hF9, 8'h88, 8'hB0, 8'h8E}, 4'h0, 3, 16'h1111, 4'h0, 12, 16'h2222);
    // 2222 shown; load 5555 during the commit cycle at the frame end.
    check_frame({8'hA4, 8'hA4, 8'hA4, 8'hA4}, 4'h0, 20, 16'h5555, 4'h0, 0, 16'h0);
    // 5555 bypassed straight into this frame; queue a blanked value.
    check_frame({8'h92, 8'h92, 8'h92, 8'h92}, 4'h0, 5, 16'h4567, 4'b1010, 0, 16'h0);
    // Digits 1 and 3 blank; slot timing unchanged.
    check_frame({8'hFF, 8'h92, 8'hFF, 8'hD8}, 4'b1010, 0, 16'h0, 4'h0, 0, 16'h0);

    // Disable mid-SCAN of digit 0.
    tick(); tick(); tick();
    chk("lit_before_disable", 32'(anode), 32'hE);
    enable = 1'b0;
    tick();
    chk("disable_anode", 32'(anode), 32'hF);
    chk("disable_seg", 32'(seg), 32'hFF);
    chk("disable_fd", 32'(frame_done), 32'd0);
    tick(); tick();
    chk("disabled_dark", 32'(anode), 32'hF);
    // Re-enable: restarts at digit 0 with the retained buffers.
    enable = 1'b1;
    wait_fd(5);
    check_frame({8'hFF, 8'h92, 8'hFF, 8'hD8}, 4'b1010, 0, 16'h0, 4'h0, 0, 16'h0);

    // Async reset mid-slot, away from any clock edge.
    tick(); tick(); tick();
    chk("lit_before_reset", 32'(seg), 32'hD8);
    #3;
    Reset = 1'b1;
    #1;
    chk("async_reset_anode", 32'(anode), 32'hF);
    chk("async_reset_seg", 32'(seg), 32'hFF);
    chk("async_reset_fd", 32'(frame_done), 32'd0);
    enable = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    chk("post_reset_dark", 32'(anode), 32'hF);
    // Buffers cleared by reset: all digits show 0 again.
    enable = 1'b1;
    wait_fd(5);
    check_frame({8'hC0, 8'hC0, 8'hC0, 8'hC0}, 4'h0, 0, 16'h0, 4'h0, 0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
